search_window_receiver: RTL and testbench
=========================================

// Module: search_window_receiver
// PURPOSE
//  Receiving end of the previous-frame buffer's row stream. Each strobed row is
//  184 bits: 23 pixels x 8 bits, one search-window row.
//  Collects WIN_ROWS rows per search window into a two-bank (ping-pong) register
//  store and tags each window with its block coordinates (x,y).
//  Replays each window to the ME PE array as a valid/ready row stream.
//  Flags overruns and partial windows.
// PARAMETERS
//  PIX_W     8    bits per pixel
//  WIN_W     23   pixels per row; row width is PIX_W*WIN_W = 184 bits
//  WIN_ROWS  23   rows per search window
//  BLK_X     480  8x8 blocks per frame row (3840/8)
//  BLK_Y     270  8x8 block rows per frame (2160/8)
// PORTS
//  clk           in   1    single clock, all logic on posedge
//  reset         in   1    synchronous, active-high
//  in_en         in   1    row strobe (driven by buffer out_en)
//  data_in       in   184  row pixels; pixel 0 in [7:0]
//  frame_end_in  in   1    one-cycle end-of-frame pulse from buffer
//  win_valid     out  1    win_data holds a valid window row
//  win_ready     in   1    PE array accepts the row
//  win_data      out  184  window row
//  win_row       out  5    row index within window, 0..WIN_ROWS-1
//  win_first     out  1    win_row==0 and win_valid
//  win_last      out  1    win_row==WIN_ROWS-1 and win_valid
//  win_x         out  9    block column tag, 1..BLK_X
//  win_y         out  9    block row tag, 1..BLK_Y
//  frame_done    out  1    one-cycle pulse: last window of frame fully accepted
//  overrun       out  1    sticky: a row was dropped because the target bank was full
//  partial_err   out  1    sticky: frame_end_in arrived with wr_row != 0
// BEHAVIOUR
//  Reset: all outputs 0. wr_bank=rd_bank=0, wr_row=0, both banks empty.
//    Position counters x=y=1. FSM in IDLE. Reset asserted mid-operation aborts
//    everything, discards both banks, and clears the sticky flags.
//  Write side:
//   - On in_en, if bank[wr_bank] is empty, store data_in at row wr_row, then
//     increment wr_row.
//   - When wr_row==WIN_ROWS-1: mark the bank full, latch tag (x,y), toggle
//     wr_bank, set wr_row<=0, and advance x. When x==BLK_X, x<=1 and
//     y<=y+1 (wrap to 1 after BLK_Y).
//   - On in_en with bank[wr_bank] full: drop the row, set overrun<=1, and
//     leave wr_row unchanged.
//   - Fullness is sampled at the start of the cycle. A bank freed by the read
//     side in the same cycle is still seen as full, so the row is dropped.
//  frame_end_in:
//   - If wr_row!=0, set partial_err<=1 and wr_row<=0; the partial rows are
//     discarded.
//   - Set x<=1 and y<=1.
//   - Full banks are unaffected and drain normally.
//   - If in_en and frame_end_in are both high, the row is processed first. If
//     it completes a window, the window is kept with its pre-reset tag. The
//     counters then reset.
//  Read FSM:
//   - IDLE: if bank[rd_bank] is full, go to STREAM with rd_row<=0.
//   - STREAM: win_valid=1, win_data=bank[rd_bank][rd_row], win_row=rd_row,
//     win_x/win_y = that bank's tag.
//   - On win_valid&&win_ready: rd_row++. On the last row, mark the bank empty,
//     toggle rd_bank, and return to IDLE (one bubble cycle between windows).
//   - While win_ready=0, win_data, win_row, win_x and win_y are held stable.
//  Latency: a row completing a window at edge E gives win_valid=1 after edge
//    E+1 (2 cycles from its in_en cycle). Sustained throughput is
//    WIN_ROWS+1 cycles per window.
//  frame_done: pulses for one cycle on the edge after the last row of the
//    window tagged (BLK_X,BLK_Y) is accepted.
// TESTING
//  1. reset=1 for 3 cycles, then idle -> all outputs 0; win_valid stays 0 with
//     no in_en.
//  2. 23 rows, row r = {23{r[7:0]}}, win_ready=1 -> win_valid 2 cycles after
//     the last in_en. 23 rows: win_row 0..22, data matches, tag (1,1),
//     win_first/win_last correct.
//  3. win_ready=0, 69 back-to-back rows -> banks hold windows (1,1) and (2,1);
//     rows 46..68 dropped; overrun=1. Release ready -> 46 rows out in order.
//  4. win_ready alternating 1/0 during a window -> each row presented for
//     exactly 2 cycles; outputs stable while stalled; no row lost or repeated.
//  5. BLK_X=4, BLK_Y=2, 8 windows -> tags (1,1)..(4,1),(1,2)..(4,2);
//     frame_done pulses once after the 8th window's last accept; the next
//     window is tagged (1,1).
//  6. frame_end_in after 10 rows -> partial_err=1, no window emitted; the next
//     23 rows emit a window tagged (1,1). Then reset mid-stream -> win_valid=0
//     the next cycle and partial_err cleared.

Source files
------------

// File: rtl/search_window_receiver_if.sv
// search_window_receiver_if: row stream in, window-row stream out, plus receiver status.
interface search_window_receiver_if #(
  parameter int ROW_W = 184,
  parameter int ROW_IW = 5
);
  logic in_en;
  logic [ROW_W-1:0] data_in;
  logic frame_end_in;
  logic win_valid;
  logic win_ready;
  logic [ROW_W-1:0] win_data;
  logic [ROW_IW-1:0] win_row;
  logic win_first;
  logic win_last;
  logic [8:0] win_x;
  logic [8:0] win_y;
  logic frame_done;
  logic overrun;
  logic partial_err;
  modport master (
    output in_en, data_in, frame_end_in, win_ready,
    input win_valid, win_data, win_row, win_first, win_last, win_x, win_y, frame_done, overrun, partial_err
  );
  modport slave (
    input in_en, data_in, frame_end_in, win_ready,
    output win_valid, win_data, win_row, win_first, win_last, win_x, win_y, frame_done, overrun, partial_err
  );
endinterface

// File: rtl/search_window_receiver.sv
// search_window_receiver: ping-pong collects search-window rows and replays them as a valid/ready stream.
module search_window_receiver #(
  parameter int PIX_W = 8,
  parameter int WIN_W = 23,
  parameter int WIN_ROWS = 23,
  parameter int BLK_X = 480,
  parameter int BLK_Y = 270,
  localparam int ROW_W = PIX_W * WIN_W,
  localparam int RW = $clog2(WIN_ROWS)
) (
  input logic clk,
  input logic reset,
  search_window_receiver_if.slave sw
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [ROW_W-1:0] mem [2][WIN_ROWS];
  logic [1:0] full;
  logic [8:0] tag_x [2];
  logic [8:0] tag_y [2];
  logic wr_bank, rd_bank;
  logic [RW-1:0] wr_row, rd_row, wr_row_nxt, nxt;
  logic [8:0] x, y;
  logic wr_ok, wr_done, acc, acc_last, load;
  always_comb begin
    wr_ok = sw.in_en && !full[wr_bank];
    wr_done = wr_ok && wr_row == RW'(WIN_ROWS - 1);
    wr_row_nxt = wr_done ? '0 : wr_ok ? wr_row + 1'b1 : wr_row;
    acc = sw.win_valid && sw.win_ready;
    acc_last = acc && rd_row == RW'(WIN_ROWS - 1);
    load = (state == IDLE && full[rd_bank]) || (acc && !acc_last);
    nxt = state == IDLE ? '0 : rd_row + 1'b1;
  end
  always_ff @(posedge clk) if (wr_ok) mem[wr_bank][wr_row] <= sw.data_in;
  // fullness is registered, so a bank freed this cycle still rejects a row arriving this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      wr_bank <= 1'b0;
      wr_row <= '0;
      x <= 9'd1;
      y <= 9'd1;
      tag_x <= '{default: '0};
      tag_y <= '{default: '0};
      sw.overrun <= 1'b0;
      sw.partial_err <= 1'b0;
    end else begin
      full <= (full & ~(acc_last ? 2'b01 << rd_bank : 2'b00)) | (wr_done ? 2'b01 << wr_bank : 2'b00);
      wr_row <= wr_row_nxt;
      if (sw.in_en && full[wr_bank]) sw.overrun <= 1'b1;
      if (wr_done) begin
        tag_x[wr_bank] <= x;
        tag_y[wr_bank] <= y;
        wr_bank <= ~wr_bank;
        x <= x == 9'(BLK_X) ? 9'd1 : x + 9'd1;
        y <= x != 9'(BLK_X) ? y : y == 9'(BLK_Y) ? 9'd1 : y + 9'd1;
      end
      if (sw.frame_end_in) begin
        if (wr_row_nxt != '0) sw.partial_err <= 1'b1;
        wr_row <= '0;
        x <= 9'd1;
        y <= 9'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_bank <= 1'b0;
      rd_row <= '0;
      sw.win_valid <= 1'b0;
      sw.win_data <= '0;
      sw.win_row <= '0;
      sw.win_first <= 1'b0;
      sw.win_last <= 1'b0;
      sw.win_x <= '0;
      sw.win_y <= '0;
      sw.frame_done <= 1'b0;
    end else begin
      sw.frame_done <= acc_last && sw.win_x == 9'(BLK_X) && sw.win_y == 9'(BLK_Y);
      if (load) begin
        state <= STREAM;
        rd_row <= nxt;
        sw.win_valid <= 1'b1;
        sw.win_data <= mem[rd_bank][nxt];
        sw.win_row <= nxt;
        sw.win_first <= nxt == '0;
        sw.win_last <= nxt == RW'(WIN_ROWS - 1);
        sw.win_x <= tag_x[rd_bank];
        sw.win_y <= tag_y[rd_bank];
      end else if (acc_last) begin
        state <= IDLE;
        rd_bank <= ~rd_bank;
        sw.win_valid <= 1'b0;
        sw.win_data <= '0;
        sw.win_row <= '0;
        sw.win_first <= 1'b0;
        sw.win_last <= 1'b0;
        sw.win_x <= '0;
        sw.win_y <= '0;
      end
    end
  end
endmodule

// File: tb/tb_search_window_receiver.sv
// tb_search_window_receiver: randomized scoreboard bench against a queue-based window model.
module tb_search_window_receiver;
  localparam int PIX_W = 8, WIN_W = 23, WIN_ROWS = 23, BLK_X = 4, BLK_Y = 2;
  localparam int ROW_W = PIX_W * WIN_W;
  typedef struct { logic [ROW_W-1:0] data; int row; int x; int y; } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  search_window_receiver_if #(.ROW_W(ROW_W), .ROW_IW(5)) sw ();
  search_window_receiver #(.PIX_W(PIX_W), .WIN_W(WIN_W), .WIN_ROWS(WIN_ROWS), .BLK_X(BLK_X), .BLK_Y(BLK_Y))
    dut (.clk(clk), .reset(reset), .sw(sw));
  always #5 clk = ~clk;
  rec_t sb[$];
  logic [ROW_W-1:0] cur[$];
  int held = 0, mx = 1, my = 1, checks = 0, passes = 0, fd_count = 0, idle_run = 0, ready_mode = 1;
  logic exp_ovr = 1'b0, exp_par = 1'b0, rel_now = 1'b0, fd_exp = 1'b0, edge_rst = 1'b1;
  logic [7:0] pb;
  rec_t e;
  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // reference model: rows gather into a window; two windows may be held; completed windows go to the scoreboard
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      cur.delete();
      held = 0; mx = 1; my = 1; exp_ovr = 1'b0; exp_par = 1'b0;
    end else begin
      if (sw.in_en) begin
        if (held == 2) exp_ovr = 1'b1;
        else begin
          cur.push_back(sw.data_in);
          if (cur.size() == WIN_ROWS) begin
            foreach (cur[i]) sb.push_back('{cur[i], i, mx, my});
            cur.delete();
            held++;
            if (mx == BLK_X) begin mx = 1; my = (my == BLK_Y) ? 1 : my + 1; end
            else mx++;
          end
        end
      end
      held -= int'(rel_now);
      if (sw.frame_end_in) begin
        if (cur.size() != 0) exp_par = 1'b1;
        cur.delete();
        mx = 1; my = 1;
      end
    end
  end
  // monitor: compares presented rows with the scoreboard front and predicts the next edge's accept
  always @(negedge clk) begin
    if (edge_rst) begin
      idle_run = 0;
      chk("reset_valid", sw.win_valid, 0);
      chk("reset_flags", {sw.overrun, sw.partial_err, sw.frame_done, sw.win_first, sw.win_last}, 0);
      chk("reset_outputs", {sw.win_data, sw.win_row, sw.win_x, sw.win_y}, 0);
    end else begin
      chk("overrun", sw.overrun, exp_ovr);
      chk("partial_err", sw.partial_err, exp_par);
      chk("frame_done", sw.frame_done, fd_exp);
      if (sw.frame_done) fd_count++;
      if (sb.size() == 0) begin
        idle_run = 0;
        chk("valid_without_window", sw.win_valid, 0);
      end else if (sw.win_valid) begin
        idle_run = 0;
        chk("win_data", sw.win_data, sb[0].data);
        chk("win_row", sw.win_row, sb[0].row);
        chk("win_tag", {sw.win_x, sw.win_y}, {9'(sb[0].x), 9'(sb[0].y)});
        chk("win_first_last", {sw.win_first, sw.win_last}, {sb[0].row == 0, sb[0].row == WIN_ROWS - 1});
      end else begin
        idle_run++;
        chk("window_latency", idle_run <= 2, 1);
        chk("first_last_idle", {sw.win_first, sw.win_last}, 0);
      end
    end
    rel_now = 1'b0;
    fd_exp = 1'b0;
    if (!reset && !edge_rst && sw.win_valid && sw.win_ready && sb.size() != 0) begin
      e = sb.pop_front();
      rel_now = e.row == WIN_ROWS - 1;
      fd_exp = rel_now && e.x == BLK_X && e.y == BLK_Y;
    end
    edge_rst = reset;
  end
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: sw.win_ready = 1'b0;
      1: sw.win_ready = 1'b1;
      2: sw.win_ready = ~sw.win_ready;
      default: sw.win_ready = 1'($urandom_range(0, 1));
    endcase
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [ROW_W-1:0] d);
    sw.in_en = 1'b1;
    sw.data_in = d;
    step();
    sw.in_en = 1'b0;
  endtask
  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < WIN_W; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom);
    return r;
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  task automatic send_window();
    for (int r = 0; r < WIN_ROWS; r++) send(rand_row());
    step();
    step();
  endtask
  task automatic drain(input int mode);
    int n = 0;
    ready_mode = mode;
    while (sb.size() != 0 && n < 600) begin step(); n++; end
    step();
    step();
    chk("drain_timeout", 32'(sb.size()), 0);
  endtask
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!sw.win_valid && n < 100) begin @(negedge clk); n++; end
    chk("wait_valid_timeout", sw.win_valid, 1);
  endtask
  initial begin
    sw.in_en = 1'b0;
    sw.data_in = '0;
    sw.frame_end_in = 1'b0;
    sw.win_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("idle_valid", sw.win_valid, 0);
    chk("idle_flags", {sw.overrun, sw.partial_err, sw.frame_done, sw.win_first, sw.win_last}, 0);
    step();
    for (int r = 0; r < WIN_ROWS; r++) begin
      pb = 8'(r);
      send({WIN_W{pb}});
    end
    @(negedge clk);
    chk("latency_one_edge", sw.win_valid, 0);
    @(negedge clk);
    chk("latency_two_edges", sw.win_valid, 1);
    chk("first_tag", {sw.win_x, sw.win_y, sw.win_first}, {9'd1, 9'd1, 1'b1});
    chk("first_data", sw.win_data, {WIN_W{8'h00}});
    step();
    drain(1);
    ready_mode = 0;
    do_reset();
    for (int r = 0; r < 3 * WIN_ROWS; r++) send(rand_row());
    @(negedge clk);
    chk("overrun_set", sw.overrun, 1);
    step();
    drain(1);
    do_reset();
    ready_mode = 2;
    send_window();
    send_window();
    drain(2);
    ready_mode = 1;
    do_reset();
    fd_count = 0;
    repeat (2 * BLK_X * BLK_Y / 2) send_window();
    drain(1);
    chk("frame_done_count", 32'(fd_count), 1);
    send_window();
    wait_valid();
    chk("wrap_tag", {sw.win_x, sw.win_y}, {9'd1, 9'd1});
    step();
    drain(1);
    do_reset();
    repeat (10) send(rand_row());
    sw.frame_end_in = 1'b1;
    step();
    sw.frame_end_in = 1'b0;
    @(negedge clk);
    chk("partial_set", sw.partial_err, 1);
    repeat (4) @(negedge clk);
    chk("partial_no_window", sw.win_valid, 0);
    step();
    send_window();
    wait_valid();
    chk("after_partial_tag", {sw.win_x, sw.win_y}, {9'd1, 9'd1});
    ready_mode = 0;
    step();
    step();
    do_reset();
    @(negedge clk);
    chk("midreset_valid", sw.win_valid, 0);
    chk("midreset_partial", sw.partial_err, 0);
    step();
    ready_mode = 3;
    for (int c = 0; c < 1500; c++) begin
      sw.in_en = $urandom_range(0, 9) < 7;
      sw.data_in = rand_row();
      sw.frame_end_in = $urandom_range(0, 199) == 0;
      step();
    end
    sw.in_en = 1'b0;
    sw.frame_end_in = 1'b0;
    drain(1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule
